// File: rtl/amba3_apb_arbiter_pkg.sv
// Shared APB definitions: transfer-phase encoding (also used by the APB VIP)
// and the watchdog sizing helper.
package pkg_amba3;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_t;

  // Width able to hold 0..timeout; a disabled watchdog still gets one bit so it elaborates.
  function automatic int wdog_width(input int timeout);
    if (timeout > 0) begin
      return $clog2(timeout + 1);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/amba3_rr_arbiter.sv
// Combinational round-robin picker: the first requester strictly after ptr
// (wrapping) wins. Generic so other interconnects can reuse it.
module amba3_rr_arbiter
  import pkg_amba3::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);

  logic found_s;
  int   pos_s;

  // Scan from ptr+1 upward, wrapping, and keep only the first hit.
  always_comb begin
    gnt     = {N{1'b0}};
    idx     = {$clog2(N){1'b0}};
    found_s = 1'b0;
    pos_s   = 0;
    for (int i = 1; i <= N; i++) begin
      pos_s = (int'(ptr) + i) % N;
      if (!found_s && req[pos_s]) begin
        found_s    = 1'b1;
        gnt[pos_s] = 1'b1;
        idx        = $clog2(N)'(pos_s);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/amba3_apb_arbiter.sv
// Round-robin share of one APB3 completer among NREQ requesters: latches the winner,
// replays it as a clean SETUP/ACCESS on the shared port, and aborts hung ACCESS phases.
module amba3_apb_arbiter
  import pkg_amba3::*;
#(
  parameter int NREQ    = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic [NREQ-1:0]         s_psel,
  input  logic [NREQ-1:0]         s_penable,
  input  logic [NREQ*AW-1:0]      s_paddr,
  input  logic [NREQ-1:0]         s_pwrite,
  input  logic [NREQ*DW-1:0]      s_pwdata,
  output logic [DW-1:0]           s_prdata,
  output logic [NREQ-1:0]         s_pready,
  output logic [NREQ-1:0]         s_pslverr,
  output logic                    m_psel,
  output logic                    m_penable,
  output logic [AW-1:0]           m_paddr,
  output logic                    m_pwrite,
  output logic [DW-1:0]           m_pwdata,
  input  logic [DW-1:0]           m_prdata,
  input  logic                    m_pready,
  input  logic                    m_pslverr,
  output logic [$clog2(NREQ)-1:0] grant,
  output logic                    busy
);

  localparam int               GW      = $clog2(NREQ);
  localparam int               WDW     = wdog_width(TIMEOUT);
  localparam logic             WDOG_EN = (TIMEOUT > 0) ? 1'b1 : 1'b0;
  localparam logic [WDW-1:0]   WD_LAST = WDOG_EN ? WDW'(TIMEOUT - 1) : {WDW{1'b0}};
  localparam logic [WDW-1:0]   WD_MAX  = {WDW{1'b1}};
  localparam logic [WDW-1:0]   WD_ONE  = {{(WDW-1){1'b0}}, 1'b1};
  localparam logic [GW-1:0]    PTR_RST = GW'(NREQ - 1);

  apb_state_t      state_r;
  apb_state_t      state_nxt_s;
  logic [GW-1:0]   grant_r;
  logic [GW-1:0]   rr_ptr_r;
  logic [GW-1:0]   win_idx_s;
  logic [NREQ-1:0] win_gnt_s;
  logic            any_req_s;
  logic            done_s;
  logic            abort_s;
  logic [WDW-1:0]  wdog_r;
  logic            m_psel_r;
  logic            m_penable_r;
  logic            m_pwrite_r;
  logic            busy_r;
  logic [AW-1:0]   m_paddr_r;
  logic [DW-1:0]   m_pwdata_r;
  logic            penable_unused_s;

  amba3_rr_arbiter #(.N(NREQ)) u_rr (
    .req (s_psel),
    .ptr (rr_ptr_r),
    .gnt (win_gnt_s),
    .idx (win_idx_s)
  );

  // PENABLE from requesters carries no information the latch needs.
  assign penable_unused_s = ^s_penable;
  assign any_req_s        = |win_gnt_s;
  assign done_s           = (state_r == APB_ACCESS) && m_pready;
  // A late PREADY on the last allowed cycle still counts as a normal completion.
  assign abort_s          = WDOG_EN && (state_r == APB_ACCESS) && (wdog_r == WD_LAST) && !m_pready;

  // Next-state logic: every transfer returns through IDLE so a stale PSEL is never re-granted.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      APB_IDLE: begin
        if (any_req_s) begin
          state_nxt_s = APB_SETUP;
        end else begin
          state_nxt_s = APB_IDLE;
        end
      end
      APB_SETUP: state_nxt_s = APB_ACCESS;
      APB_ACCESS: begin
        if (done_s || abort_s) begin
          state_nxt_s = APB_IDLE;
        end else begin
          state_nxt_s = APB_ACCESS;
        end
      end
      default: state_nxt_s = APB_IDLE;
    endcase
  end

  // State, shared-port registers, request latch, watchdog and round-robin pointer.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_r     <= APB_IDLE;
      m_psel_r    <= 1'b0;
      m_penable_r <= 1'b0;
      m_paddr_r   <= {AW{1'b0}};
      m_pwrite_r  <= 1'b0;
      m_pwdata_r  <= {DW{1'b0}};
      grant_r     <= {GW{1'b0}};
      busy_r      <= 1'b0;
      wdog_r      <= {WDW{1'b0}};
      rr_ptr_r    <= PTR_RST;
    end else begin
      state_r     <= state_nxt_s;
      m_psel_r    <= (state_nxt_s != APB_IDLE);
      m_penable_r <= (state_nxt_s == APB_ACCESS);
      busy_r      <= (state_nxt_s != APB_IDLE);
      if ((state_r == APB_IDLE) && any_req_s) begin
        grant_r    <= win_idx_s;
        m_paddr_r  <= s_paddr[int'(win_idx_s)*AW +: AW];
        m_pwrite_r <= s_pwrite[win_idx_s];
        m_pwdata_r <= s_pwdata[int'(win_idx_s)*DW +: DW];
      end
      if (state_r == APB_SETUP) begin
        wdog_r <= {WDW{1'b0}};
      end else if ((state_r == APB_ACCESS) && (wdog_r != WD_MAX)) begin
        wdog_r <= wdog_r + WD_ONE;
      end
      if (done_s) begin
        rr_ptr_r <= grant_r;
      end
    end
  end

  // Response steering: only the owner sees PREADY, and everything is quiet outside ACCESS.
  always_comb begin
    s_pready  = {NREQ{1'b0}};
    s_pslverr = {NREQ{1'b0}};
    s_prdata  = {DW{1'b0}};
    if (done_s) begin
      s_pready[grant_r]  = 1'b1;
      s_pslverr[grant_r] = m_pslverr;
      s_prdata           = m_prdata;
    end else if (abort_s) begin
      s_pready[grant_r]  = 1'b1;
      s_pslverr[grant_r] = 1'b1;
    end else begin
      s_prdata = {DW{1'b0}};
    end
  end

  assign m_psel    = m_psel_r;
  assign m_penable = m_penable_r;
  assign m_paddr   = m_paddr_r;
  assign m_pwrite  = m_pwrite_r;
  assign m_pwdata  = m_pwdata_r;
  assign grant     = grant_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_amba3_apb_arbiter.sv
// Scenario bench for amba3_apb_arbiter: directed feature tasks plus a randomized
// transfer loop scored against a transfer-level round-robin/timeout model.
module tb_amba3_apb_arbiter;

  localparam int NREQ    = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 8;
  localparam int GW      = 2;

  logic               pclk = 1'b0;
  logic               preset;
  logic [NREQ-1:0]    s_psel, s_penable, s_pwrite;
  logic [NREQ*AW-1:0] s_paddr;
  logic [NREQ*DW-1:0] s_pwdata;
  logic [DW-1:0]      s_prdata;
  logic [NREQ-1:0]    s_pready, s_pslverr;
  logic               m_psel, m_penable, m_pwrite;
  logic [AW-1:0]      m_paddr;
  logic [DW-1:0]      m_pwdata, m_prdata;
  logic               m_pready, m_pslverr;
  logic [GW-1:0]      grant;
  logic               busy;

  int checks = 0;
  int errors = 0;
  int exp_ptr;   // model: index of the last normally completed owner

  amba3_apb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .preset(preset),
    .s_psel(s_psel), .s_penable(s_penable), .s_paddr(s_paddr), .s_pwrite(s_pwrite),
    .s_pwdata(s_pwdata), .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
    .m_psel(m_psel), .m_penable(m_penable), .m_paddr(m_paddr), .m_pwrite(m_pwrite),
    .m_pwdata(m_pwdata), .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
    .grant(grant), .busy(busy)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic idle_inputs();
    s_psel = '0; s_penable = '0; s_paddr = '0; s_pwrite = '0; s_pwdata = '0;
    m_prdata = '0; m_pready = 1'b0; m_pslverr = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    s_psel[i] = 1'b1; s_penable[i] = 1'b0;
    s_paddr[i*AW +: AW] = a; s_pwrite[i] = w; s_pwdata[i*DW +: DW] = d;
  endtask

  // Round-robin rule: first requester after the last owner, wrapping.
  function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
    for (int k = 1; k <= NREQ; k++) begin
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic test_reset();
    preset = 1'b1; idle_inputs();
    tick(); s_psel = '1; tick(); #1;
    checks++;
    if ({m_psel, m_penable, m_paddr, m_pwrite, m_pwdata, grant, busy, s_pready, s_pslverr, s_prdata} !== '0)
      begin errors++; $display("FAIL reset_state got psel=%b pen=%b addr=%h grant=%0d busy=%b pready=%b", m_psel, m_penable, m_paddr, grant, busy, s_pready); end
    tick(); preset = 1'b0; idle_inputs();
    exp_ptr = NREQ - 1;
  endtask

  task automatic test_single_write();
    tick(); idle_inputs(); set_req(1, 32'h40, 1'b1, 32'hA5); m_pready = 1'b1; #1;
    checks++;
    if ({m_psel, busy, s_pready} !== 6'b0) begin errors++; $display("FAIL single_c0 got psel=%b busy=%b pready=%b exp 0", m_psel, busy, s_pready); end
    tick(); #1;
    checks++;
    if ({m_psel, m_penable, busy, grant, m_paddr, m_pwrite, m_pwdata, s_pready} !== {1'b1, 1'b0, 1'b1, 2'd1, 32'h40, 1'b1, 32'hA5, 4'b0})
      begin errors++; $display("FAIL single_setup got psel=%b pen=%b grant=%0d addr=%h wr=%b wd=%h", m_psel, m_penable, grant, m_paddr, m_pwrite, m_pwdata); end
    tick(); #1;
    checks++;
    if ({m_psel, m_penable, s_pready, s_pslverr} !== {2'b11, 4'b0010, 4'b0000})
      begin errors++; $display("FAIL single_access got psel=%b pen=%b pready=%b err=%b exp 1 1 0010 0000", m_psel, m_penable, s_pready, s_pslverr); end
    exp_ptr = 1;
    tick(); s_psel = '0; #1;
    checks++;
    if ({m_psel, m_penable, busy, s_pready, grant} !== {3'b000, 4'b0, 2'd1})
      begin errors++; $display("FAIL single_after got psel=%b pen=%b busy=%b grant=%0d", m_psel, m_penable, busy, grant); end
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] mask;
    int k, drop, win;
    tick(); preset = 1'b1; tick(); preset = 1'b0; exp_ptr = NREQ - 1;
    tick(); idle_inputs();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(32'h100 + i*4), 1'b1, 32'(i * 32'h11111111));
    m_pready = 1'b1; #1;
    mask = '1; k = 0; drop = -1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (drop >= 0) begin s_psel[drop] = 1'b0; drop = -1; end
      #1;
      checks++;
      if (k < NREQ && c == 2 + 3*k) begin
        win = rr_pick(mask, exp_ptr);
        if ({s_pready, m_paddr, grant} !== {4'b1 << win, 32'(32'h100 + win*4), GW'(win)})
          begin errors++; $display("FAIL contention_xfer%0d got pready=%b addr=%h grant=%0d exp winner %0d", k, s_pready, m_paddr, grant, win); end
        mask[win] = 1'b0; exp_ptr = win; drop = win; k++;
      end else if (s_pready !== 4'b0) begin
        errors++; $display("FAIL contention_gap c=%0d got pready=%b exp 0000", c, s_pready);
      end
    end
  endtask

  task automatic test_wait_read();
    logic [NREQ-1:0] oh;
    int win;
    tick(); idle_inputs(); set_req(2, 32'h80, 1'b0, 32'h0);
    m_prdata = 32'hDEADBEEF; m_pslverr = 1'b1; #1;
    win = rr_pick(4'b0100, exp_ptr); oh = 4'b1 << win;
    tick(); #1;
    checks++;
    if ({m_psel, grant, m_pwrite} !== {1'b1, GW'(win), 1'b0}) begin errors++; $display("FAIL wait_setup got psel=%b grant=%0d wr=%b", m_psel, grant, m_pwrite); end
    for (int a = 1; a <= 6; a++) begin
      tick(); m_pready = (a == 6); #1;
      checks++;
      if (a < 6) begin
        if ({m_penable, s_pready, s_pslverr, s_prdata} !== {1'b1, 4'b0, 4'b0, 32'h0})
          begin errors++; $display("FAIL wait_hold a=%0d got pen=%b pready=%b err=%b rdata=%h", a, m_penable, s_pready, s_pslverr, s_prdata); end
      end else if ({s_pready, s_pslverr, s_prdata} !== {oh, oh, 32'hDEADBEEF}) begin
        errors++; $display("FAIL wait_done got pready=%b err=%b rdata=%h exp %b %b deadbeef", s_pready, s_pslverr, s_prdata, oh, oh);
      end
    end
    exp_ptr = win;
    tick(); idle_inputs(); #1;
    checks++;
    if ({m_psel, s_prdata, s_pslverr} !== '0) begin errors++; $display("FAIL wait_after got psel=%b rdata=%h err=%b", m_psel, s_prdata, s_pslverr); end
  endtask

  task automatic test_timeout();
    logic [NREQ-1:0] oh;
    tick(); idle_inputs(); set_req(3, 32'hC0, 1'b1, 32'h1234); m_prdata = 32'hFFFFFFFF; #1;
    oh = 4'b1 << rr_pick(4'b1000, exp_ptr);
    tick();
    for (int a = 1; a <= TIMEOUT; a++) begin
      tick(); #1;
      checks++;
      if (a < TIMEOUT) begin
        if (s_pready !== 4'b0) begin errors++; $display("FAIL timeout_hold a=%0d got pready=%b exp 0000", a, s_pready); end
      end else if ({s_pready, s_pslverr, s_prdata} !== {oh, oh, 32'h0}) begin
        errors++; $display("FAIL timeout_abort got pready=%b err=%b rdata=%h exp %b %b 0", s_pready, s_pslverr, s_prdata, oh, oh);
      end
    end
    tick(); s_psel = '0; #1;
    checks++;
    if ({m_psel, m_penable, busy, s_pready} !== 7'b0) begin errors++; $display("FAIL timeout_after got psel=%b pen=%b busy=%b", m_psel, m_penable, busy); end
  endtask

  task automatic test_reset_access();
    int win;
    tick(); idle_inputs(); set_req(1, 32'h44, 1'b1, 32'h55); #1;
    tick(); tick(); #1;
    checks++;
    if ({m_psel, m_penable} !== 2'b11) begin errors++; $display("FAIL rst_acc_pre got psel=%b pen=%b exp 11", m_psel, m_penable); end
    tick(); preset = 1'b1; #1;
    tick(); m_pready = 1'b1; #1;
    checks++;
    if ({m_psel, m_penable, m_paddr, m_pwrite, m_pwdata, grant, busy, s_pready, s_pslverr, s_prdata} !== '0)
      begin errors++; $display("FAIL rst_acc_clear got psel=%b pen=%b addr=%h grant=%0d busy=%b pready=%b", m_psel, m_penable, m_paddr, grant, busy, s_pready); end
    tick(); preset = 1'b0; m_pready = 1'b0; set_req(0, 32'h10, 1'b0, 32'h0); #1;
    exp_ptr = NREQ - 1;
    win = rr_pick(4'b0011, exp_ptr);
    tick(); #1;
    checks++;
    if ({m_psel, grant, m_paddr} !== {1'b1, GW'(win), 32'h10}) begin errors++; $display("FAIL rst_acc_regrant got psel=%b grant=%0d addr=%h exp grant %0d", m_psel, grant, m_paddr, win); end
    tick(); m_pready = 1'b1; #1;
    checks++;
    if (s_pready !== (4'b1 << win)) begin errors++; $display("FAIL rst_acc_done got pready=%b exp owner %0d", s_pready, win); end
    exp_ptr = win;
    tick(); idle_inputs(); #1;
  endtask

  task automatic test_fairness();
    logic pend0, drop0;
    int win;
    tick(); idle_inputs(); set_req(2, 32'h200, 1'b1, 32'h2); m_pready = 1'b1; #1;
    pend0 = 1'b0; drop0 = 1'b0;
    win = rr_pick(4'b0100, exp_ptr);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) begin set_req(0, 32'h300, 1'b1, 32'h3); pend0 = 1'b1; end
      if (drop0) begin s_psel[0] = 1'b0; drop0 = 1'b0; end
      #1;
      checks++;
      if (c % 3 == 2) begin
        if ({s_pready, grant} !== {4'b1 << win, GW'(win)})
          begin errors++; $display("FAIL fair_xfer c=%0d got pready=%b grant=%0d exp owner %0d", c, s_pready, grant, win); end
        exp_ptr = win;
        if (win == 0) begin pend0 = 1'b0; drop0 = 1'b1; end
      end else if (s_pready !== 4'b0) begin
        errors++; $display("FAIL fair_gap c=%0d got pready=%b exp 0000", c, s_pready);
      end
      if (c % 3 == 0) win = rr_pick({2'b01, 1'b0, pend0}, exp_ptr);
    end
    tick(); idle_inputs(); #1;
    checks++;
    if (m_psel !== 1'b0) begin errors++; $display("FAIL fair_after got psel=%b exp 0", m_psel); end
  endtask

  task automatic test_pready_timeout_tie();
    logic [NREQ-1:0] oh;
    int win;
    tick(); idle_inputs(); set_req(1, 32'h48, 1'b0, 32'h0); m_prdata = 32'h0BADF00D; #1;
    win = rr_pick(4'b0010, exp_ptr); oh = 4'b1 << win;
    tick();
    for (int a = 1; a <= TIMEOUT; a++) begin
      tick(); m_pready = (a == TIMEOUT); #1;
      checks++;
      if (a < TIMEOUT) begin
        if (s_pready !== 4'b0) begin errors++; $display("FAIL tie_hold a=%0d got pready=%b exp 0000", a, s_pready); end
      end else if ({s_pready, s_pslverr, s_prdata} !== {oh, 4'b0, 32'h0BADF00D}) begin
        errors++; $display("FAIL tie_done got pready=%b err=%b rdata=%h exp %b 0000 0badf00d", s_pready, s_pslverr, s_prdata, oh);
      end
    end
    exp_ptr = win;
    tick(); idle_inputs(); #1;
  endtask

  task automatic test_random(input int n);
    logic [NREQ-1:0] mask, oh, eerr;
    logic [AW-1:0]   addr [NREQ];
    logic [DW-1:0]   wd [NREQ];
    logic            wr [NREQ];
    logic [DW-1:0]   rd;
    logic            err, normal;
    int              win, w, done_a;
    for (int t = 0; t < n; t++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      w = $urandom_range(0, 10); rd = $urandom; err = 1'($urandom_range(0, 1));
      tick(); idle_inputs();
      for (int i = 0; i < NREQ; i++) begin
        addr[i] = $urandom; wd[i] = $urandom; wr[i] = 1'($urandom_range(0, 1));
        if (mask[i]) set_req(i, addr[i], wr[i], wd[i]);
      end
      #1;
      win = rr_pick(mask, exp_ptr); oh = 4'b1 << win;
      normal = (w + 1 <= TIMEOUT);
      done_a = normal ? w + 1 : TIMEOUT;
      eerr = normal ? (err ? oh : 4'b0) : oh;
      tick(); #1;
      checks++;
      if ({m_psel, m_penable, grant, m_paddr, m_pwrite, m_pwdata} !== {1'b1, 1'b0, GW'(win), addr[win], wr[win], wd[win]})
        begin errors++; $display("FAIL rand_setup t=%0d got grant=%0d addr=%h wr=%b wd=%h exp grant=%0d addr=%h", t, grant, m_paddr, m_pwrite, m_pwdata, win, addr[win]); end
      for (int a = 1; a <= done_a; a++) begin
        tick(); m_prdata = rd; m_pslverr = err; m_pready = (a == w + 1); #1;
        checks++;
        if (a < done_a) begin
          if ({m_penable, s_pready, s_prdata} !== {1'b1, 4'b0, 32'h0})
            begin errors++; $display("FAIL rand_hold t=%0d a=%0d got pen=%b pready=%b rdata=%h", t, a, m_penable, s_pready, s_prdata); end
        end else if ({s_pready, s_pslverr, s_prdata} !== {oh, eerr, normal ? rd : 32'h0}) begin
          errors++; $display("FAIL rand_done t=%0d got pready=%b err=%b rdata=%h exp %b %b %h", t, s_pready, s_pslverr, s_prdata, oh, eerr, normal ? rd : 32'h0);
        end
      end
      if (normal) exp_ptr = win;
      tick(); idle_inputs(); #1;
      checks++;
      if ({m_psel, busy, s_pready} !== 6'b0) begin errors++; $display("FAIL rand_idle t=%0d got psel=%b busy=%b pready=%b", t, m_psel, busy, s_pready); end
    end
  endtask

  initial begin
    preset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_write();
    test_contention();
    test_wait_read();
    test_timeout();
    test_reset_access();
    test_fairness();
    test_pready_timeout_tie();
    test_random(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
